// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road traffic light controller:
// lamp encodings, the state enum with its debug codes, and the lamp decoder.
package traffic_pkg;

    localparam int LAMP_W = 3;

    typedef logic [LAMP_W-1:0] lamp_t;

    // Lamp vectors are {red, yellow, green}.
    localparam lamp_t RED = 3'b100;
    localparam lamp_t YEL = 3'b010;
    localparam lamp_t GRN = 3'b001;
    localparam lamp_t OFF = 3'b000;

    typedef enum logic [2:0] {
        ALLRED_BA = 3'd0,
        A_GREEN   = 3'd1,
        A_YEL     = 3'd2,
        ALLRED_AB = 3'd3,
        B_GREEN   = 3'd4,
        B_YEL     = 3'd5,
        PED_WALK  = 3'd6,
        FLASH     = 3'd7
    } state_t;

    typedef struct packed {
        lamp_t a;
        lamp_t b;
        logic  walk;
    } lamps_t;

    function automatic lamps_t decode_lamps(state_t s, logic flash_ph);
        lamps_t l;
        l.a    = RED;
        l.b    = RED;
        l.walk = 1'b0;
        case (s)
            A_GREEN:  l.a = GRN;
            A_YEL:    l.a = YEL;
            B_GREEN:  l.b = GRN;
            B_YEL:    l.b = YEL;
            PED_WALK: l.walk = 1'b1;
            FLASH: begin
                l.a = flash_ph ? YEL : OFF;
                l.b = flash_ph ? RED : OFF;
            end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Sensor/request inputs and lamp outputs of one intersection controller.
// The controller takes the slave view; whoever drives the sensors takes master.
interface traffic_light_ctrl_if;

    logic                 tick_en;
    logic                 car_b;
    logic                 ped_req;
    logic                 night;
    traffic_pkg::lamp_t   lightA;
    traffic_pkg::lamp_t   lightB;
    logic                 walk;
    logic [2:0]           state_o;

    modport master (
        output tick_en, car_b, ped_req, night,
        input  lightA, lightB, walk, state_o
    );

    modport slave (
        input  tick_en, car_b, ped_req, night,
        output lightA, lightB, walk, state_o
    );

endinterface

// File: rtl/phase_timer.sv
// Tick-driven phase counter: clears on request, advances on tick_en and
// saturates at limit-1; expire marks the tick that completes the phase.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             tick_en,
    input  logic [CNT_W-1:0] limit,
    output logic             expire,
    output logic             sat
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;

    assign last   = limit - CNT_W'(1);
    // >= keeps the counter parked even if limit shrinks under it.
    assign sat    = (cnt >= last);
    assign expire = tick_en && sat;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (tick_en && !sat) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller with timed phases, side-road sensing,
// latched pedestrian requests with an all-red walk phase, and night flashing.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int T_GREEN  = 20,
    parameter int T_YELLOW = 4,
    parameter int T_ALLRED = 2,
    parameter int T_WALK   = 10,
    parameter int T_FLASH  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    traffic_light_ctrl_if.slave  bus
);

    localparam longint T_MAX = (longint'(1) << CNT_W) - 1;

    if (T_GREEN  < 1 || T_GREEN  > T_MAX ||
        T_YELLOW < 1 || T_YELLOW > T_MAX ||
        T_ALLRED < 1 || T_ALLRED > T_MAX ||
        T_WALK   < 1 || T_WALK   > T_MAX ||
        T_FLASH  < 1 || T_FLASH  > T_MAX) begin : g_bad_timing
        $error("traffic_light_ctrl: every T_* must lie in 1 .. 2**CNT_W-1");
    end

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] limit;
    logic             expire;
    logic             sat;
    logic             clr;
    logic             ped_pend;
    logic             nxt_b;
    logic             flash_ph;
    logic             flash_ph_d;
    lamps_t           lamps_d;
    lamps_t           lamps_q;

    always_comb begin
        limit = CNT_W'(T_ALLRED);
        case (state_q)
            A_GREEN, B_GREEN: limit = CNT_W'(T_GREEN);
            A_YEL, B_YEL:     limit = CNT_W'(T_YELLOW);
            PED_WALK:         limit = CNT_W'(T_WALK);
            FLASH:            limit = CNT_W'(T_FLASH);
            default:          ;
        endcase
    end

    // FLASH restarts the count at each half-period boundary while staying put.
    assign clr = (state_d != state_q) || ((state_q == FLASH) && expire);

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .tick_en (bus.tick_en),
        .limit   (limit),
        .expire  (expire),
        .sat     (sat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ALLRED_BA;
        else        state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ALLRED_BA, ALLRED_AB: begin
                if (expire) begin
                    if (bus.night)               state_d = FLASH;
                    else if (ped_pend)           state_d = PED_WALK;
                    else if (state_q == ALLRED_AB) state_d = B_GREEN;
                    else                         state_d = A_GREEN;
                end
            end
            A_GREEN: begin
                if (bus.tick_en && sat && (bus.car_b || ped_pend || bus.night))
                    state_d = A_YEL;
            end
            A_YEL:    if (expire) state_d = ALLRED_AB;
            B_GREEN:  if (expire) state_d = B_YEL;
            B_YEL:    if (expire) state_d = ALLRED_BA;
            PED_WALK: if (expire) state_d = nxt_b ? B_GREEN : A_GREEN;
            FLASH:    if (expire && !bus.night) state_d = ALLRED_BA;
            default:  state_d = ALLRED_BA;
        endcase
    end

    // Each FLASH visit starts on the lit half-period.
    always_comb begin
        flash_ph_d = flash_ph;
        if (state_d == FLASH && state_q != FLASH) flash_ph_d = 1'b1;
        else if (state_q == FLASH && expire)      flash_ph_d = ~flash_ph;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) flash_ph <= 1'b1;
        else        flash_ph <= flash_ph_d;
    end

    // Requests arriving on the entry edge or during the walk are absorbed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ped_pend <= 1'b0;
        end else if (state_d == PED_WALK || state_q == PED_WALK) begin
            ped_pend <= 1'b0;
        end else if (bus.ped_req) begin
            ped_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nxt_b <= 1'b0;
        end else if (state_d == PED_WALK && state_q != PED_WALK) begin
            nxt_b <= (state_q == ALLRED_AB);
        end
    end

    // Lamps decode the next state so the registered outputs line up with state_q.
    always_comb begin
        lamps_d = decode_lamps(state_d, flash_ph_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lamps_q.a    <= RED;
            lamps_q.b    <= RED;
            lamps_q.walk <= 1'b0;
        end else begin
            lamps_q <= lamps_d;
        end
    end

    assign bus.lightA  = lamps_q.a;
    assign bus.lightB  = lamps_q.b;
    assign bus.walk    = lamps_q.walk;
    assign bus.state_o = state_q;

    a_never_both_go: assert property (@(posedge clk) disable iff (!reset)
        (state_q == FLASH) || (lamps_q.a == RED) || (lamps_q.b == RED));

    a_walk_all_red: assert property (@(posedge clk) disable iff (!reset)
        !lamps_q.walk || ((lamps_q.a == RED) && (lamps_q.b == RED)));

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: directed vector table, an
// asynchronous-reset sequence, and randomized traffic against a phase model.
module tb_traffic_light_ctrl;

    localparam int T_GREEN  = 4;
    localparam int T_YELLOW = 2;
    localparam int T_ALLRED = 1;
    localparam int T_WALK   = 3;
    localparam int T_FLASH  = 2;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] O = 3'b000;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    traffic_light_ctrl_if bus ();

    traffic_light_ctrl #(
        .CNT_W    (8),
        .T_GREEN  (T_GREEN),
        .T_YELLOW (T_YELLOW),
        .T_ALLRED (T_ALLRED),
        .T_WALK   (T_WALK),
        .T_FLASH  (T_FLASH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         reps;
        logic       car_b;
        logic       ped_req;
        logic       night;
        logic       tick_en;
        logic [2:0] st;
        logic [2:0] la;
        logic [2:0] lb;
        logic       w;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int reps, logic c, logic p, logic n, logic t,
                                logic [2:0] st, logic [2:0] la, logic [2:0] lb, logic w);
        vec_t v;
        v.reps = reps; v.car_b = c; v.ped_req = p; v.night = n; v.tick_en = t;
        v.st = st; v.la = la; v.lb = lb; v.w = w;
        return v;
    endfunction

    // Phase model: phase code, ticks elapsed since entering it, pending walk and
    // which green follows a walk. Durations come straight from the phase rules.
    int m_phase;
    int m_ticks;
    bit m_ped;
    bit m_nb;

    task automatic model_reset();
        m_phase = 0;
        m_ticks = 0;
        m_ped   = 1'b0;
        m_nb    = 1'b0;
    endtask

    task automatic model_step();
        int t;
        int nxt;
        t   = m_ticks + (bus.tick_en ? 1 : 0);
        nxt = m_phase;
        if (bus.tick_en) begin
            case (m_phase)
                0, 3: if (t >= T_ALLRED)
                          nxt = bus.night ? 7 : (m_ped ? 6 : (m_phase == 3 ? 4 : 1));
                1:    if (t >= T_GREEN && (bus.car_b || m_ped || bus.night)) nxt = 2;
                2:    if (t >= T_YELLOW) nxt = 3;
                4:    if (t >= T_GREEN)  nxt = 5;
                5:    if (t >= T_YELLOW) nxt = 0;
                6:    if (t >= T_WALK)   nxt = m_nb ? 4 : 1;
                7:    if ((t % T_FLASH) == 0 && !bus.night) nxt = 0;
                default: ;
            endcase
        end
        if (nxt == 6 || m_phase == 6) m_ped = 1'b0;
        else if (bus.ped_req)         m_ped = 1'b1;
        if (nxt == 6 && m_phase != 6) m_nb = (m_phase == 3);
        m_ticks = (nxt != m_phase) ? 0 : t;
        m_phase = nxt;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else        model_step();
    end

    function automatic logic [9:0] model_out();
        logic [2:0] a;
        logic [2:0] b;
        logic       w;
        a = R; b = R; w = 1'b0;
        case (m_phase)
            1: a = G;
            2: a = Y;
            4: b = G;
            5: b = Y;
            6: w = 1'b1;
            7: if (((m_ticks / T_FLASH) % 2) == 0) a = Y;
               else begin a = O; b = O; end
            default: ;
        endcase
        return {m_phase[2:0], a, b, w};
    endfunction

    function automatic logic [9:0] dut_out();
        return {bus.state_o, bus.lightA, bus.lightB, bus.walk};
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got st=%0d A=%b B=%b walk=%b, expected st=%0d A=%b B=%b walk=%b",
                     name, act[9:7], act[6:4], act[3:1], act[0],
                     exp[9:7], exp[6:4], exp[3:1], exp[0]);
        end
    endtask

    task automatic drive(logic c, logic p, logic n, logic t);
        bus.car_b   = c;
        bus.ped_req = p;
        bus.night   = n;
        bus.tick_en = t;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;

        //          reps car ped ngt tick  st  A  B  walk
        vecs.push_back(mk( 1, 0, 0, 0, 1, 3'd1, G, R, 0));  // enter A_GREEN
        vecs.push_back(mk(50, 0, 0, 0, 1, 3'd1, G, R, 0));  // hold green, no car
        vecs.push_back(mk( 2, 1, 0, 0, 1, 3'd2, Y, R, 0));  // car_b -> A_YEL
        vecs.push_back(mk( 1, 1, 0, 0, 1, 3'd3, R, R, 0));
        vecs.push_back(mk( 1, 0, 0, 0, 1, 3'd4, R, G, 0));
        vecs.push_back(mk( 1, 0, 1, 0, 1, 3'd4, R, G, 0));  // ped pulse in B_GREEN
        vecs.push_back(mk( 2, 0, 0, 0, 1, 3'd4, R, G, 0));
        vecs.push_back(mk( 2, 0, 0, 0, 1, 3'd5, R, Y, 0));
        vecs.push_back(mk( 1, 0, 0, 0, 1, 3'd0, R, R, 0));
        vecs.push_back(mk( 3, 0, 0, 0, 1, 3'd6, R, R, 1));  // walk
        vecs.push_back(mk( 1, 0, 0, 0, 1, 3'd1, G, R, 0));
        vecs.push_back(mk(10, 0, 0, 0, 1, 3'd1, G, R, 0));  // request consumed
        vecs.push_back(mk( 2, 0, 0, 1, 1, 3'd2, Y, R, 0));  // night from A_GREEN
        vecs.push_back(mk( 1, 0, 0, 1, 1, 3'd3, R, R, 0));
        vecs.push_back(mk( 2, 0, 0, 1, 1, 3'd7, Y, R, 0));  // flash lit half
        vecs.push_back(mk( 2, 0, 0, 1, 1, 3'd7, O, O, 0));  // flash dark half
        vecs.push_back(mk( 1, 0, 0, 1, 1, 3'd7, Y, R, 0));
        vecs.push_back(mk( 1, 0, 0, 0, 1, 3'd7, Y, R, 0));  // night cleared mid half
        vecs.push_back(mk( 1, 0, 0, 0, 1, 3'd0, R, R, 0));  // exit at boundary
        vecs.push_back(mk( 1, 0, 0, 0, 1, 3'd1, G, R, 0));
        vecs.push_back(mk( 3, 0, 0, 0, 1, 3'd1, G, R, 0));
        vecs.push_back(mk( 1, 1, 0, 0, 1, 3'd2, Y, R, 0));
        vecs.push_back(mk( 4, 0, 0, 0, 0, 3'd2, Y, R, 0));  // tick_en frozen
        vecs.push_back(mk( 1, 0, 1, 0, 0, 3'd2, Y, R, 0));  // ped while frozen
        vecs.push_back(mk( 5, 0, 0, 0, 0, 3'd2, Y, R, 0));
        vecs.push_back(mk( 1, 0, 0, 0, 1, 3'd2, Y, R, 0));
        vecs.push_back(mk( 1, 0, 0, 0, 1, 3'd3, R, R, 0));
        vecs.push_back(mk( 3, 0, 0, 0, 1, 3'd6, R, R, 1));  // walk after ALLRED_AB
        vecs.push_back(mk( 1, 0, 0, 0, 1, 3'd4, R, G, 0));  // resumes with B
        vecs.push_back(mk( 2, 0, 0, 0, 1, 3'd4, R, G, 0));

        repeat (3) @(negedge clk);
        check("reset_state", dut_out(), {3'd0, R, R, 1'b0});
        reset = 1'b1;

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                drive(vecs[i].car_b, vecs[i].ped_req, vecs[i].night, vecs[i].tick_en);
                @(posedge clk);
                @(negedge clk);
                check($sformatf("vec%0d.%0d", i, r), dut_out(),
                      {vecs[i].st, vecs[i].la, vecs[i].lb, vecs[i].w});
            end
        end

        // Asynchronous reset between edges in the last B_GREEN cycle.
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        check("pre_async_reset", dut_out(), {3'd4, R, G, 1'b0});
        reset = 1'b0;
        #1;
        check("async_reset", dut_out(), {3'd0, R, R, 1'b0});
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("restart%0d", i), dut_out(), {3'd1, G, R, 1'b0});
        end

        // Randomized traffic against the phase model.
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("rand_reset", dut_out(), model_out());
        reset = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bus.tick_en = ($urandom_range(0, 3) != 0);
            bus.ped_req = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0)  bus.car_b = ~bus.car_b;
            if ($urandom_range(0, 59) == 0) bus.night = ~bus.night;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("rand%0d", i), dut_out(), model_out());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Parametrised two-road intersection controller and successor to traffic_light. Drives 3-bit lamp vectors for main road A and side road B.
- Adds several features traffic_light lacks: programmable phase durations, a tick-enable time base (no slow clock needed), side-road car sensing with main-road green hold, latched pedestrian requests with an all-red walk phase, and a night flashing mode.
- Sits directly under the intersection top level. tick_en comes from the shared prescaler.

Parameters:
- CNT_W, 8, phase counter width.
- T_GREEN, 20, ticks of minimum green for A and fixed green for B.
- T_YELLOW, 4, ticks of yellow.
- T_ALLRED, 2, ticks of all-red clearance.
- T_WALK, 10, ticks of pedestrian walk.
- T_FLASH, 5, ticks per flash half-period.
- Legal values: every T_* is at least 1 and at most 2**CNT_W-1. Elaboration fails otherwise.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- tick_en  in  1  time-base strobe; counters advance only when it is 1.
- car_b  in  1  side-road vehicle present (level).
- ped_req  in  1  pedestrian request; a 1 in any clk cycle is latched.
- night  in  1  night-mode request (level).
- lightA  out  3  road A lamps {red, yellow, green}.
- lightB  out  3  road B lamps {red, yellow, green}.
- walk  out  1  pedestrian walk lamp.
- state_o  out  3  current state code, for debug.

Behaviour:
- Lamp encodings: RED=100, YEL=010, GRN=001, OFF=000. All outputs are registered and decoded from the state register.
- Reset asserted, asynchronously:
  - state is ALLRED_BA, cnt=0, ped_pend=0, nxt_b=0, flash_ph=1.
  - lightA=lightB=100, walk=0.
- Phase timer: cnt clears to 0 on every state entry. It increments on tick_en. A phase "expires" on a cycle where tick_en=1 and cnt==T-1, so each phase lasts exactly T ticks.
- States and transitions:
  - ALLRED_BA: A=RED, B=RED. On expiry go to FLASH if night=1, else PED_WALK if ped_pend=1, else A_GREEN.
  - A_GREEN: A=GRN, B=RED.
    - Once cnt reaches T_GREEN-1, cnt saturates.
    - Go to A_YEL on a tick where the count is saturated and (car_b or ped_pend or night) is 1. Otherwise hold green indefinitely.
  - A_YEL: A=YEL, B=RED. T_YELLOW, then ALLRED_AB.
  - ALLRED_AB: both RED. On expiry go to FLASH if night=1, else PED_WALK if ped_pend=1, else B_GREEN.
  - B_GREEN: A=RED, B=GRN. Fixed T_GREEN, then B_YEL.
  - B_YEL: A=RED, B=YEL. T_YELLOW, then ALLRED_BA.
  - PED_WALK: both RED, walk=1.
    - On entry, nxt_b records the green that would have followed: 1 for B after ALLRED_AB, 0 for A after ALLRED_BA.
    - After T_WALK ticks go to B_GREEN if nxt_b=1, else A_GREEN. No extra all-red phase.
  - FLASH: A = YEL when flash_ph=1, else OFF. B = RED when flash_ph=1, else OFF. walk=0.
    - flash_ph toggles every T_FLASH ticks.
    - At a toggle boundary with night=0, go to ALLRED_BA. Exit therefore occurs only at a boundary.
- ped_pend:
  - Set by ped_req=1 in any cycle.
  - Cleared on the clock that enters PED_WALK. A request in that cycle or during PED_WALK is absorbed, not re-latched.
  - Held through FLASH and served at the next all-red expiry.
- Priority at all-red expiry: night, then ped_pend, then normal sequence.
- The tick_en=0 cycles freeze cnt and flash_ph. Inputs are still sampled: ped_req is still latched.
- state_o codes:
  - ALLRED_BA=0, A_GREEN=1, A_YEL=2, ALLRED_AB=3
  - B_GREEN=4, B_YEL=5, PED_WALK=6, FLASH=7
- Safety invariant: lightA and lightB are never both non-RED in a non-FLASH state. Assert this in simulation.

Decomposition:
- Package traffic_pkg holds:
  - the state enum with the codes above;
  - the lamp constants RED, YEL, GRN, OFF;
  - the lamp-vector width (3).
- One sub-module, phase_timer. Parameter CNT_W. Inputs clk, reset, clr, tick_en, limit. Outputs expire and sat. It saturates at limit-1.

Test Plan:
Bench parameters: T_GREEN=4, T_YELLOW=2, T_ALLRED=1, T_WALK=3, T_FLASH=2, tick_en tied to 1.
1. Release reset with car_b=0 → A_GREEN is entered 1 clk after release. A stays 001 and B stays 100 for 50 clks.
2. From case 1, raise car_b=1 → next clk A_YEL (A=010) for 2 clks, then ALLRED_AB (1 clk), then B_GREEN 4 clks, B_YEL 2 clks, ALLRED_BA 1 clk, then A_GREEN.
3. Pulse ped_req for 1 clk during B_GREEN → after B_YEL and ALLRED_BA, walk=1 for 3 clks with both lamps 100, then A_GREEN. ped_pend=0 afterwards.
4. Set night=1 during A_GREEN with the count saturated → A_YEL, ALLRED_AB, then FLASH. A alternates 010/000 and B alternates 100/000, each for 2 clks. Clear night mid-half-period → exit only at the next boundary to ALLRED_BA, then A_GREEN.
5. Hold tick_en=0 for 10 clks during A_YEL → state and lamps frozen. A ped_req pulse in that window is still served at the next all-red.
6. Assert reset mid-B_GREEN, asynchronously between edges → lightA=lightB=100 and walk=0 immediately. Restart proceeds as in case 1.
